// File: rtl/program_loader.sv
// Boot loader: streams program words into the core's instruction image, holding the core in reset while loading.
// Latency: one cycle from an accepted word to load_ins/word_count; core released HOLD_CYCLES edges after the final word.
// Backpressure: in_ready is registered, high for the whole of LOAD, and drops on the edge that accepts the final word.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   start                    begin a (re)load; honoured in IDLE or RUN only
//   in_valid/in_data/in_last program word stream (first word -> slot 0)
//   in_ready                 loader accepts a word this cycle
//   load_ins                 instruction image, slot k = bits [32k+31:32k]
//   core_reset               active-high reset to the core
//   word_count               words accepted in the current load
//   busy / done              LOAD or HOLD / RUN
module program_loader #(
   parameter int          WORDS       = 32,
   parameter int          HOLD_CYCLES = 2,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic                         in_valid,
   input  logic [31:0]                  in_data,
   input  logic                         in_last,
   output logic                         in_ready,
   output logic [WORDS*32-1:0]          load_ins,
   output logic                         core_reset,
   output logic [$clog2(WORDS+1)-1:0]   word_count,
   output logic                         busy,
   output logic                         done
);

   localparam int             CW        = $clog2(WORDS + 1);
   localparam logic [CW-1:0]  LAST_IDX  = CW'(WORDS - 1);
   localparam logic [3:0]     HOLD_INIT = 4'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_RUN
   } state_t;

   state_t     state;
   logic [3:0] hold_cnt;

   // in_ready is only ever high in LOAD, so it doubles as the transfer qualifier.
   logic beat;
   assign beat = in_valid && in_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         hold_cnt   <= '0;
         load_ins   <= '0;
         core_reset <= 1'b1;
         in_ready   <= 1'b0;
         word_count <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_RUN: begin
               if (start) begin
                  // Pre-fill with NOP so a short program never runs stale slots.
                  state      <= S_LOAD;
                  load_ins   <= {WORDS{NOP_WORD}};
                  word_count <= '0;
                  core_reset <= 1'b1;
                  in_ready   <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
               end
            end

            S_LOAD: begin
               if (beat) begin
                  for (int k = 0; k < WORDS; k++) begin
                     if (word_count == CW'(k))
                        load_ins[32*k +: 32] <= in_data;
                  end
                  word_count <= word_count + 1'b1;
                  // The final slot forces completion, so the image can never overflow.
                  if (in_last || (word_count == LAST_IDX)) begin
                     state    <= S_HOLD;
                     in_ready <= 1'b0;
                     hold_cnt <= HOLD_INIT;
                  end
               end
            end

            S_HOLD: begin
               if (hold_cnt == 4'd0) begin
                  state      <= S_RUN;
                  core_reset <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt - 4'd1;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   localparam int          WORDS = 32;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_last;

   // u0: default hold of 2, u1: hold of 4; both see identical stimulus.
   logic                 rdy0, cr0, busy0, done0;
   logic [WORDS*32-1:0]  img0;
   logic [5:0]           wc0;
   logic                 rdy1, cr1, busy1, done1;
   logic [WORDS*32-1:0]  img1;
   logic [5:0]           wc1;

   program_loader u0 (
      .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_last(in_last), .in_ready(rdy0), .load_ins(img0),
      .core_reset(cr0), .word_count(wc0), .busy(busy0), .done(done0)
   );

   program_loader #(.HOLD_CYCLES(4)) u1 (
      .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_last(in_last), .in_ready(rdy1), .load_ins(img1),
      .core_reset(cr1), .word_count(wc1), .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: the image as an array of slots plus a count of stored words.
   logic [31:0] exp_slot [WORDS];
   int          exp_cnt;

   function automatic logic [WORDS*32-1:0] exp_image();
      logic [WORDS*32-1:0] v;
      for (int k = 0; k < WORDS; k++) v[32*k +: 32] = exp_slot[k];
      return v;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < WORDS; k++) exp_slot[k] = 32'h0;
      exp_cnt = 0;
   endtask

   task automatic model_fill();
      for (int k = 0; k < WORDS; k++) exp_slot[k] = NOP;
      exp_cnt = 0;
   endtask

   task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      model_fill();
   endtask

   // One handshaked beat, optionally preceded by idle cycles; in_valid stays high afterwards.
   task automatic beat(input logic [31:0] d, input logic last, input int gap);
      in_valid = 1'b0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      chk("ready_before_beat", rdy0, 1'b1);
      tick();
      in_last = 1'b0;
      exp_slot[exp_cnt] = d;
      exp_cnt++;
      chk("count_after_beat", wc0, exp_cnt);
   endtask

   // Called just after the final beat's edge; junk words are offered throughout HOLD.
   task automatic measure_release(input string tag, input logic [31:0] junk);
      int rel0, rel1;
      rel0 = 0;
      rel1 = 0;
      chk({tag, "_ready_drop"}, {rdy0, rdy1}, 2'b00);
      chk({tag, "_reset_held"}, {cr0, cr1}, 2'b11);
      in_valid = 1'b1;
      in_data  = junk;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (rel0 == 0 && cr0 == 1'b0) rel0 = i;
         if (rel1 == 0 && cr1 == 1'b0) rel1 = i;
      end
      in_valid = 1'b0;
      chk({tag, "_release_h2"}, rel0, 2);
      chk({tag, "_release_h4"}, rel1, 4);
      chk({tag, "_done_busy"}, {done0, busy0, done1, busy1}, 4'b1010);
      chk({tag, "_image"}, img0, exp_image());
      chk({tag, "_image_h4"}, img1, exp_image());
      chk({tag, "_count"}, wc0, exp_cnt);
   endtask

   logic [31:0] r;

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 32'h0;
      in_last  = 1'b0;
      model_clear();

      // Reset state
      #12;
      chk("rst_image", img0, exp_image());
      chk("rst_core_reset", cr0, 1'b1);
      chk("rst_ready", rdy0, 1'b0);
      chk("rst_count", wc0, 0);
      chk("rst_busy_done", {busy0, done0}, 2'b00);
      reset_n = 1'b1;
      tick();

      // Words offered in IDLE are ignored
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      repeat (3) tick();
      in_valid = 1'b0;
      chk("idle_image", img0, exp_image());
      chk("idle_count", wc0, 0);
      chk("idle_ready", rdy0, 1'b0);

      // Short program: three beats, in_last on the third
      do_start();
      chk("start_ready_busy", {rdy0, busy0, cr0}, 3'b111);
      chk("start_nop_fill", img0, exp_image());
      chk("start_count", wc0, 0);
      beat(32'h0050_0093, 1'b0, 0);
      beat(32'h0030_0113, 1'b0, 0);
      beat(32'h0020_81B3, 1'b1, 0);
      measure_release("short", 32'hDEAD_BEEF);

      // start in RUN: restart with reset re-asserted and NOP fill
      do_start();
      chk("rerun_reset_done", {cr0, done0}, 2'b10);
      chk("rerun_nop_fill", img0, exp_image());
      chk("rerun_count", wc0, 0);

      // Full image at 1 word/cycle, no in_last; 33rd word must be refused
      for (int i = 0; i < WORDS; i++) begin
         r = $urandom;
         beat(r, 1'b0, 0);
      end
      chk("full_slot31", img0[32*31 +: 32], exp_slot[31]);
      measure_release("full", $urandom);

      // Gappy stream of 5 words with a stray start mid-load
      do_start();
      for (int i = 0; i < 5; i++) begin
         r = $urandom;
         if (i == 2) begin
            in_valid = 1'b0;
            start    = 1'b1;
            tick();
            start    = 1'b0;
            chk("midload_start_count", wc0, exp_cnt);
            chk("midload_start_image", img0, exp_image());
         end
         beat(r, i == 4, $urandom_range(0, 2));
      end
      measure_release("gappy", 32'hDEAD_BEEF);

      // Restart after the 5-word load
      do_start();
      chk("restart5_reset_done", {cr0, done0, cr1, done1}, 4'b1010);
      chk("restart5_nop_fill", img0, exp_image());
      chk("restart5_count", {wc0, wc1}, 12'd0);

      // Asynchronous reset after 10 of 20 words
      for (int i = 0; i < 10; i++) begin
         r = $urandom;
         beat(r, 1'b0, 0);
      end
      #2;
      reset_n = 1'b0;
      #1;
      model_clear();
      chk("arst_image", img0, exp_image());
      chk("arst_outputs", {rdy0, cr0, busy0, done0}, 4'b0100);
      chk("arst_count", wc0, 0);
      in_data = 32'hDEAD_BEEF;
      repeat (3) tick();
      chk("arst_beats_ignored", img0, exp_image());
      reset_n = 1'b1;
      repeat (4) tick();
      in_valid = 1'b0;
      chk("post_arst_image", img0, exp_image());
      chk("post_arst_count", wc0, 0);
      chk("post_arst_needs_start", {rdy0, cr0, busy0}, 3'b010);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
